dw_add_pipe: RTL and testbench

Parametrised, pipelined successor to the fixed 8-bit adder macro. It adds, subtracts, increments or passes operands of configurable width. The carry chain is split into `STAGES` registered segments, giving a higher clock rate at a latency of `STAGES` cycles. It sits in the datapath library as a drop-in arithmetic unit with a valid/ready handshake on both sides.

---
 rtl/dw_add_pipe.sv | 134 +++++++++++++
 tb/tb_dw_add_pipe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dw_add_pipe.sv
// rtl/dw_add_pipe.sv - pipelined add/sub/inc/pass unit, carry chain split into STAGES segments
// Optional saturation when DW_ADD_PIPE_SAT_EN is defined.
module dw_add_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic [1:0]       MODE,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             CO,
  output logic             OUT_VALID,
  input  logic             OUT_READY
`ifdef DW_ADD_PIPE_SAT_EN
  ,
  input  logic             SAT
`endif
);
  localparam int SEG = WIDTH / STAGES;

  logic             stall;
  logic [WIDTH-1:0] in_b;
  logic             in_c;

  assign stall    = OUT_VALID & ~OUT_READY;
  assign IN_READY = ~RST & ~stall;

  // Every mode is reduced to A + in_b + in_c; PASS adds zero so CO stays 0.
  always_comb begin
    in_b = '0;
    in_c = 1'b0;
    case (MODE)
      2'b00: begin in_b = B;  in_c = CI;   end
      2'b01: begin in_b = ~B; in_c = 1'b1; end
      2'b10: in_c = 1'b1;
      default: ;
    endcase
  end

`ifdef DW_ADD_PIPE_SAT_EN
  logic in_shi, in_slo;
  assign in_shi = SAT & ~MODE[0];
  assign in_slo = SAT & (MODE == 2'b01);
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // Stage k consumes the low SEG bits of sb; the remaining upper B bits travel on.
    localparam int BW = WIDTH - k * SEG;
    logic [WIDTH-1:0] sx, nx, x_q;
    logic [BW-1:0]    sb;
    logic             sc, sv, c_q, v_q;
    logic [SEG:0]     seg;
`ifdef DW_ADD_PIPE_SAT_EN
    logic             shi, slo;
`endif

    if (k == 0) begin : g_src
      assign sx = A;
      assign sb = in_b;
      assign sc = in_c;
      assign sv = IN_VALID & IN_READY;
`ifdef DW_ADD_PIPE_SAT_EN
      assign shi = in_shi;
      assign slo = in_slo;
`endif
    end else begin : g_src
      assign sx = g_stg[k-1].x_q;
      assign sb = g_stg[k-1].g_fwd.b_q;
      assign sc = g_stg[k-1].c_q;
      assign sv = g_stg[k-1].v_q;
`ifdef DW_ADD_PIPE_SAT_EN
      assign shi = g_stg[k-1].g_fwd.shi_q;
      assign slo = g_stg[k-1].g_fwd.slo_q;
`endif
    end

    assign seg = {1'b0, sx[k*SEG +: SEG]} + {1'b0, sb[SEG-1:0]} + {{SEG{1'b0}}, sc};

    always_comb begin
      nx = sx;
      nx[k*SEG +: SEG] = seg[SEG-1:0];
`ifdef DW_ADD_PIPE_SAT_EN
      if (k == STAGES - 1) begin
        if (shi & seg[SEG])  nx = '1;
        if (slo & ~seg[SEG]) nx = '0;
      end
`endif
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        x_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (!stall) begin
        x_q <= nx;
        c_q <= seg[SEG];
        v_q <= sv;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [BW-SEG-1:0] b_q;
`ifdef DW_ADD_PIPE_SAT_EN
      logic shi_q, slo_q;
`endif
      always_ff @(posedge CLK) begin
        if (RST) begin
          b_q <= '0;
`ifdef DW_ADD_PIPE_SAT_EN
          shi_q <= 1'b0;
          slo_q <= 1'b0;
`endif
        end else if (!stall) begin
          b_q <= sb[BW-1:SEG];
`ifdef DW_ADD_PIPE_SAT_EN
          shi_q <= shi;
          slo_q <= slo;
`endif
        end
      end
    end
  end

  assign SUM       = g_stg[STAGES-1].x_q;
  assign CO        = g_stg[STAGES-1].c_q;
  assign OUT_VALID = g_stg[STAGES-1].v_q;

endmodule

// File: tb/tb_dw_add_pipe.sv
// tb/tb_dw_add_pipe.sv - self-checking bench for dw_add_pipe (8-bit directed/random, 16-bit STAGES sweep)
// Saturation cases run when DW_ADD_PIPE_SAT_EN is defined.
module tb_dw_add_pipe;
`ifdef DW_ADD_PIPE_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cnt   = 0;
  always @(posedge clk) cnt <= cnt + 1;

  logic       rst;
  logic [7:0] a8, b8, sum8;
  logic       ci8, iv8, ir8, co8, ov8, or8, sat8;
  logic [1:0] m8;

  dw_add_pipe #(.WIDTH(8), .STAGES(2)) dut8 (
    .CLK(clk), .RST(rst), .A(a8), .B(b8), .CI(ci8), .MODE(m8),
    .IN_VALID(iv8), .IN_READY(ir8), .SUM(sum8), .CO(co8),
    .OUT_VALID(ov8), .OUT_READY(or8)
`ifdef DW_ADD_PIPE_SAT_EN
    , .SAT(sat8)
`endif
  );

  logic [15:0] a16, b16;
  logic        ci16, iv16, sat16;
  logic [1:0]  m16;
  logic [15:0] sum16 [3];
  logic        co16 [3];
  logic        ov16 [3];
  logic        ir16 [3];
  int          sts [3] = '{1, 4, 16};

  for (genvar i = 0; i < 3; i++) begin : g_sw
    dw_add_pipe #(.WIDTH(16), .STAGES(i == 0 ? 1 : (i == 1 ? 4 : 16))) u (
      .CLK(clk), .RST(rst), .A(a16), .B(b16), .CI(ci16), .MODE(m16),
      .IN_VALID(iv16), .IN_READY(ir16[i]), .SUM(sum16[i]), .CO(co16[i]),
      .OUT_VALID(ov16[i]), .OUT_READY(1'b1)
`ifdef DW_ADD_PIPE_SAT_EN
      , .SAT(sat16)
`endif
    );
  end

  // Reference: plain integer arithmetic; bit 16 = CO, low bits = SUM.
  function automatic logic [16:0] model(int w, logic [15:0] a, logic [15:0] b,
                                        logic ci, logic [1:0] m, logic sat);
    longint    full, mask;
    logic      co;
    logic [15:0] s;
    mask = (longint'(1) << w) - 1;
    case (m)
      2'd0:    full = longint'(a) + longint'(b) + longint'(ci);
      2'd1:    full = longint'(a) + (longint'(1) << w) - longint'(b);
      2'd2:    full = longint'(a) + 1;
      default: full = longint'(a);
    endcase
    co = (m != 2'd3) && (((full >> w) & 1) != 0);
    s  = 16'(full & mask);
    if (sat) begin
      if ((m == 2'd0 || m == 2'd2) && co) s = 16'(mask);
      if (m == 2'd1 && !co) s = '0;
    end
    return {co, s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic [1:0] m, input logic sat,
                      input logic [7:0] es, input logic eco);
    int n;
    a8 = a; b8 = b; ci8 = ci; m8 = m; sat8 = sat; iv8 = 1'b1; or8 = 1'b1;
    #1;
    chk({tag, "_rdy"}, 32'(ir8), 1);
    step();
    iv8 = 1'b0;
    n = 1;
    while (!ov8 && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, n, 2);
    chk({tag, "_sum"}, 32'(sum8), 32'(es));
    chk({tag, "_co"}, 32'(co8), 32'(eco));
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [16:0] q8 [$];
    logic [16:0] qd [3][$];
    int          qc [3][$];
    logic [16:0] e;
    logic        hold, was_stall;
    logic [7:0]  held;
    int          acc;

    rst = 1'b1; a8 = '0; b8 = '0; ci8 = 1'b0; m8 = '0; iv8 = 1'b0; or8 = 1'b1; sat8 = 1'b0;
    a16 = '0; b16 = '0; ci16 = 1'b0; m16 = '0; iv16 = 1'b0; sat16 = 1'b0;
    repeat (3) step();
    chk("rst_sum", 32'(sum8), 0);
    chk("rst_co", 32'(co8), 0);
    chk("rst_ov", 32'(ov8), 0);
    chk("rst_rdy", 32'(ir8), 0);
    rst = 1'b0;
    #1;
    chk("rel_rdy", 32'(ir8), 1);

    run8("inc_ff", 8'hFF, 8'h00, 1'b0, 2'b10, 1'b0, 8'h00, 1'b1);
    run8("inc_0f", 8'h0F, 8'h33, 1'b1, 2'b10, 1'b0, 8'h10, 1'b0);
    run8("add_80", 8'h80, 8'h80, 1'b1, 2'b00, 1'b0, 8'h01, 1'b1);
    run8("sub_57", 8'h05, 8'h07, 1'b0, 2'b01, 1'b0, 8'hFE, 1'b0);
    run8("sub_75", 8'h07, 8'h05, 1'b0, 2'b01, 1'b0, 8'h02, 1'b1);
    run8("pass", 8'hA5, 8'hFF, 1'b1, 2'b11, 1'b0, 8'hA5, 1'b0);
`ifdef DW_ADD_PIPE_SAT_EN
    run8("sat_add", 8'hF0, 8'h20, 1'b0, 2'b00, 1'b1, 8'hFF, 1'b1);
    run8("sat_sub", 8'h01, 8'h02, 1'b0, 2'b01, 1'b1, 8'h00, 1'b0);
    run8("wrap_add", 8'hF0, 8'h20, 1'b0, 2'b00, 1'b0, 8'h10, 1'b1);
    run8("wrap_sub", 8'h01, 8'h02, 1'b0, 2'b01, 1'b0, 8'hFF, 1'b0);
`endif

    // Four back-to-back INCs with a 3-cycle downstream stall on the first result.
    m8 = 2'b10; or8 = 1'b1; iv8 = 1'b1; a8 = 8'd0;
    #1 chk("str_rdy0", 32'(ir8), 1);
    step();
    a8 = 8'd1;
    #1 chk("str_rdy1", 32'(ir8), 1);
    step();
    chk("str_ov1", 32'(ov8), 1);
    chk("str_sum1", 32'(sum8), 1);
    a8 = 8'd2; or8 = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_rdy", 32'(ir8), 0);
      chk("stall_ov", 32'(ov8), 1);
      chk("stall_sum", 32'(sum8), 1);
      step();
    end
    chk("stall_end_sum", 32'(sum8), 1);
    or8 = 1'b1;
    #1 chk("unstall_rdy", 32'(ir8), 1);
    step();
    chk("str_sum2", 32'(sum8), 2);
    a8 = 8'd3;
    step();
    chk("str_sum3", 32'(sum8), 3);
    iv8 = 1'b0;
    step();
    chk("str_ov4", 32'(ov8), 1);
    chk("str_sum4", 32'(sum8), 4);
    step();
    chk("str_done", 32'(ov8), 0);

    // Reset with two operations in flight.
    m8 = 2'b10; iv8 = 1'b1; a8 = 8'h05;
    step();
    a8 = 8'h06;
    step();
    iv8 = 1'b0; rst = 1'b1;
    #1 chk("mid_rst_rdy", 32'(ir8), 0);
    step();
    chk("mid_rst_ov", 32'(ov8), 0);
    chk("mid_rst_sum", 32'(sum8), 0);
    chk("mid_rst_co", 32'(co8), 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_rst_quiet", 32'(ov8), 0);
    end
    run8("post_rst", 8'h41, 8'h00, 1'b0, 2'b10, 1'b0, 8'h42, 1'b0);

    // Random 8-bit traffic with random bubbles and downstream stalls.
    hold = 1'b0; was_stall = 1'b0; held = '0;
    for (int i = 0; i < 300; i++) begin
      if (was_stall) chk("rnd_hold", 32'(sum8), 32'(held));
      or8 = ($urandom_range(0, 3) != 0);
      if (!hold) begin
        iv8 = ($urandom_range(0, 2) != 0);
        a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
        m8 = 2'($urandom); sat8 = 1'($urandom);
      end
      #1;
      chk("rnd_ready", 32'(ir8), 32'(!(ov8 && !or8)));
      if (ov8 && or8) begin
        if (q8.size() == 0) chk("rnd_extra", 32'(ov8), 0);
        else begin
          e = q8.pop_front();
          chk("rnd_sum", 32'(sum8), 32'(e[7:0]));
          chk("rnd_co", 32'(co8), 32'(e[16]));
        end
      end
      if (iv8 && ir8) q8.push_back(model(8, 16'(a8), 16'(b8), ci8, m8, sat8 & SAT_EN));
      hold = iv8 && !ir8;
      was_stall = ov8 && !or8;
      held = sum8;
      step();
    end
    iv8 = 1'b0; or8 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (ov8) begin
        if (q8.size() == 0) chk("drain_extra", 32'(ov8), 0);
        else begin
          e = q8.pop_front();
          chk("drain_sum", 32'(sum8), 32'(e[7:0]));
          chk("drain_co", 32'(co8), 32'(e[16]));
        end
      end
      step();
    end
    chk("rnd_drain", q8.size(), 0);

    // 16-bit sweep over STAGES = 1, 4, 16: data and latency.
    for (int i = 0; i < 240; i++) begin
      if (i < 200) begin
        iv16 = ($urandom_range(0, 3) != 0);
        a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom);
        m16 = 2'($urandom); sat16 = 1'($urandom);
      end else iv16 = 1'b0;
      #1;
      if (iv16) begin
        for (int j = 0; j < 3; j++) begin
          qd[j].push_back(model(16, a16, b16, ci16, m16, sat16 & SAT_EN));
          qc[j].push_back(cnt + 1);
        end
      end
      step();
      for (int j = 0; j < 3; j++) begin
        chk("sw_rdy", 32'(ir16[j]), 1);
        if (ov16[j]) begin
          if (qd[j].size() == 0) chk("sw_extra", 32'(ov16[j]), 0);
          else begin
            e = qd[j].pop_front();
            acc = qc[j].pop_front();
            chk($sformatf("sw%0d_sum", sts[j]), 32'(sum16[j]), 32'(e[15:0]));
            chk($sformatf("sw%0d_co", sts[j]), 32'(co16[j]), 32'(e[16]));
            chk($sformatf("sw%0d_lat", sts[j]), cnt - acc + 1, sts[j]);
          end
        end
      end
    end
    for (int j = 0; j < 3; j++) chk($sformatf("sw%0d_drain", sts[j]), qd[j].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
